// File: rtl/switch_debounce3.sv
`default_nettype none
// ============================================================================
//  Module   : switch_debounce3
//  Purpose  : Synchronise and debounce three slide switches. Emits one-cycle
//             toggle strobes and a retriggerable, time-stretched buzzer enable.
//  Revision : 1.0  initial release
// ============================================================================
module switch_debounce3 #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int BEEP_CYCLES     = 5000000,
   parameter int CNT_W           = 20,
   parameter int BEEP_W          = 23
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] sw_raw,
   output logic       S3,
   output logic       S2,
   output logic       S1,
   output logic [2:0] toggle,
   output logic       Buzzer
);

   localparam logic [CNT_W-1:0]  c_cnt_last  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [BEEP_W-1:0] c_beep_load = BEEP_W'(BEEP_CYCLES);

   logic [2:0]        r_sync0;
   logic [2:0]        r_sync1;
   logic [2:0]        w_level;
   logic [2:0]        w_toggle;
   logic [BEEP_W-1:0] r_beep_cnt;

   // Plain two-flop synchroniser; nothing may sit between the stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync0 <= 3'b000;
         r_sync1 <= 3'b000;
      end else begin
         r_sync0 <= sw_raw;
         r_sync1 <= r_sync0;
      end
   end

   genvar ch;
   generate
      for (ch = 0; ch < 3; ch++) begin : g_chan
         logic [CNT_W-1:0] r_cnt;
         logic             r_level;
         logic             r_toggle;

         // Any agreement between input and output restarts the qualification window.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_cnt    <= '0;
               r_level  <= 1'b0;
               r_toggle <= 1'b0;
            end else if (r_sync1[ch] == r_level) begin
               r_cnt    <= '0;
               r_toggle <= 1'b0;
            end else if (r_cnt == c_cnt_last) begin
               r_cnt    <= '0;
               r_level  <= r_sync1[ch];
               r_toggle <= 1'b1;
            end else begin
               r_cnt    <= r_cnt + 1'b1;
               r_toggle <= 1'b0;
            end
         end

         assign w_level[ch]  = r_level;
         assign w_toggle[ch] = r_toggle;
      end
   endgenerate

   // Reload rather than accumulate so a burst of flips gives one continuous chirp.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_beep_cnt <= '0;
      end else if (|w_toggle) begin
         r_beep_cnt <= c_beep_load;
      end else if (r_beep_cnt != '0) begin
         r_beep_cnt <= r_beep_cnt - 1'b1;
      end
   end

   assign S3     = w_level[2];
   assign S2     = w_level[1];
   assign S1     = w_level[0];
   assign toggle = w_toggle;
   assign Buzzer = (r_beep_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_switch_debounce3
//  Purpose  : Directed self-checking bench for switch_debounce3 (4/3 cycles).
//  Revision : 1.0  initial release
// ============================================================================
module tb_switch_debounce3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] sw_raw = 3'b000;
   logic       S3, S2, S1, Buzzer;
   logic [2:0] toggle;

   int vectors    = 0;
   int miscompares = 0;

   switch_debounce3 #(
      .DEBOUNCE_CYCLES(4),
      .BEEP_CYCLES    (3),
      .CNT_W          (20),
      .BEEP_W         (23)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .sw_raw(sw_raw),
      .S3    (S3),
      .S2    (S2),
      .S1    (S1),
      .toggle(toggle),
      .Buzzer(Buzzer)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [2:0] sw);
      sw_raw = sw;
      rst    = 1'b1;
      step();
      step();
      rst    = 1'b0;
   endtask

   task automatic test_reset();
      sw_raw = 3'b101;
      rst    = 1'b1;
      step();
      step();
      vectors++;
      if ({S3, S2, S1, toggle, Buzzer} !== 7'b000_000_0) begin
         miscompares++;
         $display("FAIL reset_state got %b expected 0000000", {S3, S2, S1, toggle, Buzzer});
      end
      rst = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         step();
         vectors++;
         if ({S3, S2, S1} !== ((e >= 6) ? 3'b101 : 3'b000)) begin
            miscompares++;
            $display("FAIL reset_release_level edge %0d got %b", e, {S3, S2, S1});
         end
         vectors++;
         if (toggle !== ((e == 6) ? 3'b101 : 3'b000)) begin
            miscompares++;
            $display("FAIL reset_release_toggle edge %0d got %b", e, toggle);
         end
      end
   endtask

   task automatic test_clean_step();
      do_reset(3'b000);
      sw_raw = 3'b001;
      for (int e = 1; e <= 12; e++) begin
         step();
         vectors++;
         if (S1 !== (e >= 6)) begin
            miscompares++;
            $display("FAIL clean_s1 edge %0d got %b expected %b", e, S1, (e >= 6));
         end
         vectors++;
         if (toggle !== ((e == 6) ? 3'b001 : 3'b000)) begin
            miscompares++;
            $display("FAIL clean_toggle edge %0d got %b", e, toggle);
         end
         vectors++;
         if (Buzzer !== (e >= 7 && e <= 9)) begin
            miscompares++;
            $display("FAIL clean_buzzer edge %0d got %b expected %b", e, Buzzer, (e >= 7 && e <= 9));
         end
      end
   endtask

   task automatic test_bounce();
      int strobes = 0;
      do_reset(3'b000);
      for (int p = 0; p < 4; p++) begin
         sw_raw[1] = (p % 2 == 0) ? 1'b1 : 1'b0;
         for (int c = 0; c < 2; c++) begin
            step();
            vectors++;
            if (toggle !== 3'b000 || S2 !== 1'b0) begin
               miscompares++;
               $display("FAIL bounce_quiet phase %0d got toggle %b S2 %b", p, toggle, S2);
            end
         end
      end
      sw_raw[1] = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         step();
         if (toggle[1]) strobes++;
         vectors++;
         if (S2 !== (e >= 6)) begin
            miscompares++;
            $display("FAIL bounce_s2 edge %0d got %b expected %b", e, S2, (e >= 6));
         end
      end
      vectors++;
      if (strobes !== 1) begin
         miscompares++;
         $display("FAIL bounce_strobes got %0d expected 1", strobes);
      end
   endtask

   task automatic test_glitch();
      do_reset(3'b000);
      sw_raw = 3'b100;
      for (int e = 1; e <= 14; e++) begin
         step();
         if (e == 3) sw_raw = 3'b000;
         vectors++;
         if ({S3, toggle, Buzzer} !== 5'b0_000_0) begin
            miscompares++;
            $display("FAIL glitch edge %0d got S3/toggle/Buzzer %b", e, {S3, toggle, Buzzer});
         end
      end
   endtask

   task automatic test_retrigger();
      do_reset(3'b000);
      sw_raw = 3'b001;
      for (int e = 1; e <= 14; e++) begin
         step();
         if (e == 2) sw_raw = 3'b011;
         vectors++;
         if (toggle !== ((e == 6) ? 3'b001 : (e == 8) ? 3'b010 : 3'b000)) begin
            miscompares++;
            $display("FAIL retrig_toggle edge %0d got %b", e, toggle);
         end
         vectors++;
         if (Buzzer !== (e >= 7 && e <= 11)) begin
            miscompares++;
            $display("FAIL retrig_buzzer edge %0d got %b expected %b", e, Buzzer, (e >= 7 && e <= 11));
         end
      end
   endtask

   task automatic test_walk();
      logic [2:0] prev;
      logic [2:0] cur;
      int bits;
      do_reset(3'b000);
      prev = 3'b000;
      for (int v = 1; v < 8; v++) begin
         cur    = 3'(v);
         sw_raw = cur;
         bits   = 0;
         for (int e = 1; e <= 20; e++) begin
            step();
            bits += $countones(toggle);
            if (e == 5) begin
               vectors++;
               if ({S3, S2, S1} !== prev) begin
                  miscompares++;
                  $display("FAIL walk_early v %0d got %b expected %b", v, {S3, S2, S1}, prev);
               end
            end
            if (e == 6) begin
               vectors++;
               if ({S3, S2, S1} !== cur || toggle !== (prev ^ cur)) begin
                  miscompares++;
                  $display("FAIL walk_edge6 v %0d got S %b toggle %b expected S %b toggle %b",
                           v, {S3, S2, S1}, toggle, cur, prev ^ cur);
               end
            end
         end
         vectors++;
         if (bits !== $countones(prev ^ cur)) begin
            miscompares++;
            $display("FAIL walk_hamming v %0d got %0d expected %0d", v, bits, $countones(prev ^ cur));
         end
         prev = cur;
      end
   endtask

   initial begin
      test_reset();
      test_clean_step();
      test_bounce();
      test_glitch();
      test_retrigger();
      test_walk();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
